vixen_trace_fifo: RTL and testbench



---
 rtl/vixen_trace_pkg.sv | 33 +++
 rtl/vixen_trace_ram.sv | 26 ++
 rtl/vixen_trace_fifo.sv | 122 ++++++++++++
 tb/tb_vixen_trace_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vixen_trace_pkg.sv
// Shared trace record layout and event kinds for the vixen execution-trace capture path.
package vixen_trace_pkg;

    localparam int REC_W     = 38;
    localparam int PC_LSB    = 0;
    localparam int OP_LSB    = 16;
    localparam int FLAGS_LSB = 32;
    localparam int KIND_LSB  = 36;

    // Flag nibble order inside the record: {N,Z,C,V}
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    localparam logic [1:0] KIND_NORMAL = 2'b00;
    localparam logic [1:0] KIND_HALT   = 2'b01;
    localparam logic [1:0] KIND_TRAP   = 2'b10;
    localparam logic [1:0] KIND_GAP    = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_STOPPED
    } state_t;

    function automatic logic [REC_W-1:0] pack_rec(input logic [1:0]  kind,
                                                  input logic [3:0]  flags,
                                                  input logic [15:0] op,
                                                  input logic [15:0] pc);
        return {kind, flags, op, pc};
    endfunction

endpackage

// File: rtl/vixen_trace_ram.sv
// Trace record storage: registered write port, asynchronous read port for show-ahead.
module vixen_trace_ram
    import vixen_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [REC_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [REC_W-1:0] rdata
);

    logic [REC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vixen_trace_fifo.sv
// Execution-trace capture: records executed instructions into a show-ahead FIFO,
// freezes on halt/trap, and accounts for events lost to a full buffer via GAP records.
module vixen_trace_fifo
    import vixen_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             ex_valid,
    input  logic [15:0]      ex_pc,
    input  logic [15:0]      ex_op,
    input  logic [3:0]       ex_flags,
    input  logic             ex_halt,
    input  logic             ex_trap,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [REC_W-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic [15:0]      dropped,
    output logic             stopped
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state, state_nxt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             gap_pending;
    logic [15:0]      gap_count;
    logic             accept, space, pop, gap_wr, ev_wr, push, drop;
    logic [1:0]       ev_kind;
    logic [REC_W-1:0] wdata;

    assign rd_valid = (count != '0);
    assign stopped  = (state == ST_STOPPED);

    always_comb begin
        accept  = ex_valid & enable & (state == ST_RUN);
        pop     = rd_valid & rd_ready;
        space   = (count != FULL) | rd_ready;
        // A pending GAP record always wins the single write slot over a new event
        gap_wr  = gap_pending & space;
        ev_wr   = accept & ~gap_pending & space;
        drop    = accept & ~ev_wr;
        push    = gap_wr | ev_wr;
        ev_kind = ex_trap ? KIND_TRAP : (ex_halt ? KIND_HALT : KIND_NORMAL);
        wdata   = gap_wr ? pack_rec(KIND_GAP, 4'h0, 16'h0000, gap_count)
                         : pack_rec(ev_kind, ex_flags, ex_op, ex_pc);
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_RUN;
        end else if (accept && (ex_halt || ex_trap)) begin
            state_nxt = ST_STOPPED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            dropped     <= 16'd0;
            gap_pending <= 1'b0;
            gap_count   <= 16'd0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            dropped     <= 16'd0;
            gap_pending <= 1'b0;
            gap_count   <= 16'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow    <= 1'b1;
                dropped     <= sat_inc16(dropped);
                gap_pending <= 1'b1;
                gap_count   <= gap_wr ? 16'd1 : sat_inc16(gap_count);
            end else if (gap_wr) begin
                gap_pending <= 1'b0;
                gap_count   <= 16'd0;
            end
        end
    end

    vixen_trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push & ~clear),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_vixen_trace_fifo.sv
// Scoreboard bench for vixen_trace_fifo: directed events, queued expected records, negedge monitor.
module tb_vixen_trace_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        ex_valid = 1'b0;
    logic [15:0] ex_pc = '0;
    logic [15:0] ex_op = '0;
    logic [3:0]  ex_flags = '0;
    logic        ex_halt = 1'b0;
    logic        ex_trap = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [37:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] dropped;
    logic        stopped;

    int tests = 0;
    int fails = 0;
    logic [37:0] exp_q[$];

    vixen_trace_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .ex_valid (ex_valid),
        .ex_pc    (ex_pc),
        .ex_op    (ex_op),
        .ex_flags (ex_flags),
        .ex_halt  (ex_halt),
        .ex_trap  (ex_trap),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow),
        .dropped  (dropped),
        .stopped  (stopped)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] rec(input logic [1:0] k, input logic [3:0] f,
                                        input logic [15:0] op, input logic [15:0] pc);
        return {k, f, op, pc};
    endfunction

    task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [15:0] pc, input logic [15:0] op, input logic [3:0] fl,
                      input logic h, input logic t);
        ex_valid = 1'b1;
        ex_pc    = pc;
        ex_op    = op;
        ex_flags = fl;
        ex_halt  = h;
        ex_trap  = t;
        cyc();
        ex_valid = 1'b0;
        ex_halt  = 1'b0;
        ex_trap  = 1'b0;
    endtask

    // Monitor: every accepted head entry is compared with the oldest expectation
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", rd_data, 38'h3F_FFFF_FFFF);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_count", 38'(count), 38'd0);
        chk("rst_rd_valid", 38'(rd_valid), 38'd0);
        chk("rst_overflow", 38'(overflow), 38'd0);
        chk("rst_dropped", 38'(dropped), 38'd0);
        chk("rst_stopped", 38'(stopped), 38'd0);
        enable = 1'b1;

        // Basic capture then in-order drain
        exp_q.push_back(rec(2'b00, 4'b1000, 16'h1234, 16'h0000));
        ev(16'h0000, 16'h1234, 4'b1000, 1'b0, 1'b0);
        exp_q.push_back(rec(2'b00, 4'b0100, 16'h5678, 16'h0002));
        ev(16'h0002, 16'h5678, 4'b0100, 1'b0, 1'b0);
        chk("basic_count2", 38'(count), 38'd2);
        rd_ready = 1'b1;
        cyc();
        cyc();
        rd_ready = 1'b0;
        chk("basic_count0", 38'(count), 38'd0);

        // Halt freezes capture
        exp_q.push_back(rec(2'b01, 4'b0010, 16'hA000, 16'h0010));
        ev(16'h0010, 16'hA000, 4'b0010, 1'b1, 1'b0);
        ev(16'h0012, 16'hB000, 4'b0000, 1'b0, 1'b0);
        chk("halt_stopped", 38'(stopped), 38'd1);
        chk("halt_count1", 38'(count), 38'd1);
        chk("halt_no_drop", 38'(dropped), 38'd0);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_stopped", 38'(stopped), 38'd0);
        chk("clear_count", 38'(count), 38'd0);

        // Overflow: 19 events into 16 entries
        for (int i = 0; i < 19; i++) begin
            if (i < 16) exp_q.push_back(rec(2'b00, 4'b0000, 16'h0100 + 16'(i), 16'(2 * i)));
            ev(16'(2 * i), 16'h0100 + 16'(i), 4'b0000, 1'b0, 1'b0);
        end
        chk("ovf_count", 38'(count), 38'd16);
        chk("ovf_flag", 38'(overflow), 38'd1);
        chk("ovf_dropped", 38'(dropped), 38'd3);
        // One pop frees the slot the GAP record takes in the same cycle
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("gap_count16", 38'(count), 38'd16);
        exp_q.push_back(rec(2'b11, 4'b0000, 16'h0000, 16'h0003));
        // Full with simultaneous pop and event: no drop, record lands at tail
        exp_q.push_back(rec(2'b00, 4'b0101, 16'hC0DE, 16'h0026));
        rd_ready = 1'b1;
        ev(16'h0026, 16'hC0DE, 4'b0101, 1'b0, 1'b0);
        rd_ready = 1'b0;
        chk("fullpop_count", 38'(count), 38'd16);
        chk("fullpop_dropped", 38'(dropped), 38'd3);
        rd_ready = 1'b1;
        repeat (16) cyc();
        rd_ready = 1'b0;
        chk("drain_count", 38'(count), 38'd0);
        chk("drain_queue_empty", 38'(exp_q.size()), 38'd0);

        // Clear wipes content and counters; event in the clear cycle is discarded
        ev(16'h0040, 16'h1111, 4'b0000, 1'b0, 1'b0);
        ev(16'h0042, 16'h2222, 4'b0000, 1'b0, 1'b0);
        clear = 1'b1;
        ev(16'h0044, 16'h3333, 4'b0000, 1'b0, 1'b0);
        clear = 1'b0;
        chk("clr_count", 38'(count), 38'd0);
        chk("clr_rd_valid", 38'(rd_valid), 38'd0);
        chk("clr_overflow", 38'(overflow), 38'd0);
        chk("clr_dropped", 38'(dropped), 38'd0);

        // Trap wins over halt
        exp_q.push_back(rec(2'b10, 4'b0011, 16'hFFFF, 16'h0030));
        ev(16'h0030, 16'hFFFF, 4'b0011, 1'b1, 1'b1);
        chk("trap_stopped", 38'(stopped), 38'd1);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // enable low ignores events entirely
        enable = 1'b0;
        for (int i = 0; i < 5; i++) ev(16'h0050 + 16'(2 * i), 16'h4444, 4'b0000, i == 2, 1'b0);
        chk("en_count", 38'(count), 38'd0);
        chk("en_dropped", 38'(dropped), 38'd0);
        chk("en_stopped", 38'(stopped), 38'd0);
        enable = 1'b1;

        // Async reset while holding 7 entries and stopped
        for (int i = 0; i < 7; i++) ev(16'h0060 + 16'(2 * i), 16'h5555, 4'b0000, i == 6, 1'b0);
        chk("pre_rst_count", 38'(count), 38'd7);
        chk("pre_rst_stopped", 38'(stopped), 38'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_count", 38'(count), 38'd0);
        chk("arst_rd_valid", 38'(rd_valid), 38'd0);
        chk("arst_stopped", 38'(stopped), 38'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Capture resumes normally after reset
        exp_q.push_back(rec(2'b00, 4'b1111, 16'h9ABC, 16'h0100));
        ev(16'h0100, 16'h9ABC, 4'b1111, 1'b0, 1'b0);
        chk("post_rst_count", 38'(count), 38'd1);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("final_queue_empty", 38'(exp_q.size()), 38'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
